// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of (pc, instr) pairs.
// Latency: an entry enqueued at edge N is visible on deq_* in cycle N+1 (no bypass).
// Backpressure: enq_ready drops only when full (no ready-through); hold/deq_ready stall dequeue.
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_valid,
    input  logic [PC_W-1:0]            enq_pc,
    input  logic [INSTR_W-1:0]         enq_instr,
    output logic                       enq_ready,
    output logic                       deq_valid,
    output logic [PC_W-1:0]            deq_pc,
    output logic [INSTR_W-1:0]         deq_instr,
    input  logic                       deq_ready,
    input  logic                       hold,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               enq_fire;
    logic               deq_fire;

    // Handshake status and head presentation come only from registered state;
    // an empty queue shows an all-zero bubble to decode.
    always_comb begin
        enq_ready = (count_q != CNT_W'(DEPTH));
        deq_valid = (count_q != '0);
        deq_pc    = deq_valid ? mem_q[head_q].pc    : '0;
        deq_instr = deq_valid ? mem_q[head_q].instr : '0;
        count     = count_q;
    end

    // Transfer qualification: flush drops both sides, hold only blocks the dequeue.
    always_comb begin
        enq_fire = enq_valid && enq_ready && !flush;
        deq_fire = deq_valid && deq_ready && !hold && !flush;
    end

    // Next-state for pointers, occupancy and storage; flush wins over normal operation.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq_fire) begin
                mem_d[tail_q] = '{pc: enq_pc, instr: enq_instr};
                tail_d        = tail_q + PTR_W'(1);
            end
            if (deq_fire) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, ordering, full, streaming, hold, flush, reset-when-full.
// Latency: inputs driven #1 after posedge, outputs checked after the next posedge + #1.
// Backpressure: exercised via full queue, hold and deq_ready.
module tb_fetch_queue;

    localparam int DEPTH   = 4;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    logic                  clk;
    logic                  reset;
    logic                  enq_valid;
    logic [PC_W-1:0]       enq_pc;
    logic [INSTR_W-1:0]    enq_instr;
    logic                  enq_ready;
    logic                  deq_valid;
    logic [PC_W-1:0]       deq_pc;
    logic [INSTR_W-1:0]    deq_instr;
    logic                  deq_ready;
    logic                  hold;
    logic                  flush;
    logic [$clog2(DEPTH):0] count;

    int checks   = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_instr (enq_instr),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_instr (deq_instr),
        .deq_ready (deq_ready),
        .hold      (hold),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = 1'b0;
        enq_pc    = '0;
        enq_instr = '0;
        deq_ready = 1'b0;
        hold      = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic enq_one(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins);
        enq_valid = 1'b1;
        enq_pc    = pc;
        enq_instr = ins;
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL reset_deq_valid: got %b expected 0", deq_valid); end
        checks++; if (deq_pc !== 64'd0) begin failures++; $display("FAIL reset_deq_pc: got %h expected 0", deq_pc); end
        checks++; if (deq_instr !== 32'd0) begin failures++; $display("FAIL reset_deq_instr: got %h expected 0", deq_instr); end
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end
    endtask

    task automatic test_basic();
        idle_inputs();
        enq_one(64'h8000_0000, 32'h0000_0013);
        checks++; if (deq_valid !== 1'b1 || deq_pc !== 64'h8000_0000) begin failures++; $display("FAIL basic_latency: got v=%b pc=%h expected v=1 pc=80000000", deq_valid, deq_pc); end
        enq_one(64'h8000_0004, 32'h0010_0093);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL basic_count2: got %0d expected 2", count); end
        checks++; if (deq_pc !== 64'h8000_0000) begin failures++; $display("FAIL basic_head_pc: got %h expected 80000000", deq_pc); end
        checks++; if (deq_instr !== 32'h0000_0013) begin failures++; $display("FAIL basic_head_instr: got %h expected 00000013", deq_instr); end
        deq_ready = 1'b1;
        tick();
        checks++; if (deq_pc !== 64'h8000_0004 || deq_instr !== 32'h0010_0093) begin failures++; $display("FAIL basic_second: got pc=%h instr=%h expected 80000004/00100093", deq_pc, deq_instr); end
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL basic_count1: got %0d expected 1", count); end
        tick();
        deq_ready = 1'b0;
        checks++; if (deq_valid !== 1'b0) begin failures++; $display("FAIL basic_empty_valid: got %b expected 0", deq_valid); end
        checks++; if (deq_instr !== 32'd0 || deq_pc !== 64'd0) begin failures++; $display("FAIL basic_bubble: got pc=%h instr=%h expected 0/0", deq_pc, deq_instr); end
    endtask

    task automatic test_full();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) enq_one(64'h100 + 64'(4 * i), 32'h1000 + 32'(i));
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d expected 4", count); end
        checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL full_enq_ready: got %b expected 0", enq_ready); end
        enq_valid = 1'b1;
        enq_pc    = 64'hDEAD;
        enq_instr = 32'hDEAD;
        deq_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL full_simul_count: got %0d expected 3", count); end
        checks++; if (deq_pc !== 64'h104) begin failures++; $display("FAIL full_simul_head: got %h expected 104", deq_pc); end
        for (int i = 2; i < DEPTH; i++) begin
            tick();
            checks++; if (deq_pc !== 64'h100 + 64'(4 * i) || deq_instr !== 32'h1000 + 32'(i)) begin failures++; $display("FAIL full_drain_%0d: got pc=%h instr=%h expected pc=%h", i, deq_pc, deq_instr, 64'h100 + 64'(4 * i)); end
        end
        tick();
        deq_ready = 1'b0;
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0) begin failures++; $display("FAIL full_drained: got count=%0d v=%b expected 0/0", count, deq_valid); end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq_valid = 1'b1;
            enq_pc    = 64'h2000 + 64'(4 * i);
            enq_instr = 32'h2000 + 32'(i);
            tick();
            checks++; if (deq_valid !== 1'b1 || deq_pc !== 64'h2000 + 64'(4 * i) || deq_instr !== 32'h2000 + 32'(i)) begin failures++; $display("FAIL stream_head_%0d: got v=%b pc=%h instr=%h expected pc=%h", i, deq_valid, deq_pc, deq_instr, 64'h2000 + 64'(4 * i)); end
            checks++; if (count !== 3'd1) begin failures++; $display("FAIL stream_count_%0d: got %0d expected 1", i, count); end
        end
        enq_valid = 1'b0;
        tick();
        deq_ready = 1'b0;
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0) begin failures++; $display("FAIL stream_end: got count=%0d v=%b expected 0/0", count, deq_valid); end
    endtask

    task automatic test_hold();
        logic [PC_W-1:0] exp_cnt [3];
        exp_cnt[0] = 3; exp_cnt[1] = 4; exp_cnt[2] = 4;
        idle_inputs();
        enq_one(64'h3000, 32'h3000);
        enq_one(64'h3004, 32'h3001);
        hold      = 1'b1;
        deq_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            enq_valid = (c < 2);
            enq_pc    = 64'h3008 + 64'(4 * c);
            enq_instr = 32'h3002 + 32'(c);
            tick();
            checks++; if (deq_pc !== 64'h3000 || deq_instr !== 32'h3000) begin failures++; $display("FAIL hold_head_%0d: got pc=%h instr=%h expected 3000/3000", c, deq_pc, deq_instr); end
            checks++; if (64'(count) !== exp_cnt[c]) begin failures++; $display("FAIL hold_count_%0d: got %0d expected %0d", c, count, exp_cnt[c]); end
        end
        enq_valid = 1'b0;
        hold      = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if (deq_pc !== 64'h3000 + 64'(4 * i) || deq_instr !== 32'h3000 + 32'(i)) begin failures++; $display("FAIL hold_drain_%0d: got pc=%h instr=%h expected pc=%h", i, deq_pc, deq_instr, 64'h3000 + 64'(4 * i)); end
        end
        tick();
        deq_ready = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL hold_drained: got %0d expected 0", count); end
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int i = 0; i < 3; i++) enq_one(64'h4000 + 64'(4 * i), 32'h4000 + 32'(i));
        flush     = 1'b1;
        enq_valid = 1'b1;
        enq_pc    = 64'hBAD;
        enq_instr = 32'hBAD;
        deq_ready = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++; if (deq_valid !== 1'b0 || deq_instr !== 32'd0) begin failures++; $display("FAIL flush_bubble: got v=%b instr=%h expected 0/0", deq_valid, deq_instr); end
        enq_pc    = 64'h8000_1000;
        enq_instr = 32'h0000_006F;
        deq_ready = 1'b0;
        tick();
        enq_valid = 1'b0;
        checks++; if (count !== 3'd1 || deq_pc !== 64'h8000_1000 || deq_instr !== 32'h6F) begin failures++; $display("FAIL flush_target: got count=%0d pc=%h instr=%h expected 1/80001000/6f", count, deq_pc, deq_instr); end
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0) begin failures++; $display("FAIL flush_alone: got count=%0d v=%b expected 0/0", count, deq_valid); end
    endtask

    task automatic test_reset_full();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) enq_one(64'h5000 + 64'(4 * i), 32'h5000 + 32'(i));
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL rstfull_pre_count: got %0d expected 4", count); end
        hold      = 1'b1;
        deq_ready = 1'b1;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        hold  = 1'b0;
        deq_ready = 1'b0;
        checks++; if (count !== 3'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1) begin failures++; $display("FAIL rstfull_status: got count=%0d v=%b rdy=%b expected 0/0/1", count, deq_valid, enq_ready); end
        checks++; if (deq_pc !== 64'd0 || deq_instr !== 32'd0) begin failures++; $display("FAIL rstfull_data: got pc=%h instr=%h expected 0/0", deq_pc, deq_instr); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_hold();
        test_flush();
        test_reset_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
